// File: rtl/sc1602_bus_scheduler.sv
// HD44780 4-bit bus owner for the Pmod SC1602: power-on init, then round-robin
// sharing of the bus between two byte-level requesters with open-loop timing.
module sc1602_bus_scheduler #(
    parameter int T_POWERON = 405000,
    parameter int T_SETUP   = 2,
    parameter int T_E_HIGH  = 7,
    parameter int T_INIT1   = 121500,
    parameter int T_INIT2   = 2700,
    parameter int T_CMD     = 1080,
    parameter int T_CLR     = 44000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_byte,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_byte,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_db,
    output logic       init_done,
    output logic       busy,
    output logic [4:0] dbg_state
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_POWERON, T_SETUP), max2(T_E_HIGH, T_INIT1)),
                                max2(max2(T_INIT2, T_CMD), T_CLR));
    localparam int CW = $clog2(T_MAX) + 1;

    // Counters count down to zero, so each state is loaded with its length minus one.
    localparam logic [CW-1:0] C_POWERON = CW'(T_POWERON - 1);
    localparam logic [CW-1:0] C_SETUP   = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] C_E_HIGH  = CW'(T_E_HIGH - 1);
    localparam logic [CW-1:0] C_INIT1   = CW'(T_INIT1 - 1);
    localparam logic [CW-1:0] C_INIT2   = CW'(T_INIT2 - 1);
    localparam logic [CW-1:0] C_CMD     = CW'(T_CMD - 1);
    localparam logic [CW-1:0] C_CLR     = CW'(T_CLR - 1);

    localparam logic [4:0] S_PWR_WAIT = 5'd0;
    localparam logic [4:0] S_SETUP    = 5'd1;
    localparam logic [4:0] S_PULSE    = 5'd2;
    localparam logic [4:0] S_HOLD     = 5'd3;
    localparam logic [4:0] S_WAIT     = 5'd4;
    localparam logic [4:0] S_IDLE     = 5'd5;

    // Init table entry: {single_nibble, byte}; single-nibble steps send only byte[7:4].
    function automatic logic [8:0] init_entry(input logic [2:0] step);
        case (step)
            3'd0, 3'd1, 3'd2: return {1'b1, 8'h30};
            3'd3:             return {1'b1, 8'h20};
            3'd4:             return {1'b0, 8'h28};
            3'd5:             return {1'b0, 8'h0C};
            3'd6:             return {1'b0, 8'h01};
            default:          return {1'b0, 8'h06};
        endcase
    endfunction

    logic [4:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    step_r;
    logic          cur_rs_r;
    logic [7:0]    cur_byte_r;
    logic          hi_r;
    logic          single_r;
    logic          last_grant_r;

    logic          idle_s;
    logic          cnt_zero_s;
    logic [CW-1:0] wait_len_s;
    logic [8:0]    first_entry_s;
    logic [8:0]    next_entry_s;

    assign idle_s        = (state_r == S_IDLE) && !rst;
    assign cnt_zero_s    = (cnt_r == {CW{1'b0}});
    assign first_entry_s = init_entry(3'd0);
    assign next_entry_s  = init_entry(step_r + 3'd1);
    assign req0_ready    = idle_s && req0_valid && (!req1_valid || last_grant_r);
    assign req1_ready    = idle_s && req1_valid && (!req0_valid || !last_grant_r);
    assign busy          = (state_r != S_IDLE) || req0_ready || req1_ready;
    assign lcd_rw        = 1'b0;
    assign dbg_state     = state_r;

    // Execution wait that follows the nibble or byte just sent.
    always_comb begin
        wait_len_s = C_CMD;
        if (single_r && (step_r == 3'd0)) begin
            wait_len_s = C_INIT1;
        end else if (single_r && (step_r == 3'd1)) begin
            wait_len_s = C_INIT2;
        end else if (!single_r && !cur_rs_r && (cur_byte_r >= 8'h01) && (cur_byte_r <= 8'h03)) begin
            wait_len_s = C_CLR;
        end else begin
            wait_len_s = C_CMD;
        end
    end

    // Sequencer: countdown per state, nibble/byte stepping, init table and arbitration capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_PWR_WAIT;
            cnt_r        <= C_POWERON;
            step_r       <= 3'd0;
            cur_rs_r     <= 1'b0;
            cur_byte_r   <= 8'h00;
            hi_r         <= 1'b1;
            single_r     <= 1'b0;
            last_grant_r <= 1'b1;
            init_done    <= 1'b0;
            lcd_e        <= 1'b0;
            lcd_rs       <= 1'b0;
            lcd_db       <= 4'h0;
        end else if ((state_r <= S_WAIT) && !cnt_zero_s) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            case (state_r)
                S_PWR_WAIT: begin
                    state_r    <= S_SETUP;
                    cnt_r      <= C_SETUP;
                    step_r     <= 3'd0;
                    single_r   <= first_entry_s[8];
                    cur_byte_r <= first_entry_s[7:0];
                    cur_rs_r   <= 1'b0;
                    hi_r       <= 1'b1;
                    lcd_rs     <= 1'b0;
                    lcd_db     <= first_entry_s[7:4];
                end
                S_SETUP: begin
                    state_r <= S_PULSE;
                    cnt_r   <= C_E_HIGH;
                    lcd_e   <= 1'b1;
                end
                S_PULSE: begin
                    state_r <= S_HOLD;
                    cnt_r   <= C_SETUP;
                    lcd_e   <= 1'b0;
                end
                S_HOLD: begin
                    if (hi_r && !single_r) begin
                        state_r <= S_SETUP;
                        cnt_r   <= C_SETUP;
                        hi_r    <= 1'b0;
                        lcd_db  <= cur_byte_r[3:0];
                    end else begin
                        state_r <= S_WAIT;
                        cnt_r   <= wait_len_s;
                    end
                end
                S_WAIT: begin
                    if (init_done) begin
                        state_r <= S_IDLE;
                    end else if (step_r == 3'd7) begin
                        state_r   <= S_IDLE;
                        init_done <= 1'b1;
                    end else begin
                        state_r    <= S_SETUP;
                        cnt_r      <= C_SETUP;
                        step_r     <= step_r + 3'd1;
                        single_r   <= next_entry_s[8];
                        cur_byte_r <= next_entry_s[7:0];
                        cur_rs_r   <= 1'b0;
                        hi_r       <= 1'b1;
                        lcd_rs     <= 1'b0;
                        lcd_db     <= next_entry_s[7:4];
                    end
                end
                S_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        state_r      <= S_SETUP;
                        cnt_r        <= C_SETUP;
                        hi_r         <= 1'b1;
                        single_r     <= 1'b0;
                        last_grant_r <= req1_ready;
                        cur_rs_r     <= req1_ready ? req1_rs : req0_rs;
                        cur_byte_r   <= req1_ready ? req1_byte : req0_byte;
                        lcd_rs       <= req1_ready ? req1_rs : req0_rs;
                        lcd_db       <= req1_ready ? req1_byte[7:4] : req0_byte[7:4];
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_PWR_WAIT;
                    cnt_r   <= C_POWERON;
                    lcd_e   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc1602_bus_scheduler.sv
// Randomized bench for sc1602_bus_scheduler against a timeline model: when the bus
// is next free, which port wins, and which nibbles appear at each E fall.
module tb_sc1602_bus_scheduler;

    localparam int TP = 20, TS = 2, TE = 4, TI1 = 50, TI2 = 10, TC = 8, TCLR = 30;
    localparam int NIB = 2 * TS + TE;
    localparam int XFER = 2 * NIB;
    localparam int INIT_TOTAL = TP + 4 * NIB + TI1 + TI2 + 2 * TC + 4 * XFER + 3 * TC + TCLR;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_rs = 1'b0, req1_valid = 1'b0, req1_rs = 1'b0;
    logic [7:0] req0_byte = 8'h00, req1_byte = 8'h00;
    logic       req0_ready, req1_ready, lcd_rs, lcd_rw, lcd_e, init_done, busy;
    logic [3:0] lcd_db;
    logic [4:0] dbg_state;

    sc1602_bus_scheduler #(
        .T_POWERON(TP), .T_SETUP(TS), .T_E_HIGH(TE), .T_INIT1(TI1),
        .T_INIT2(TI2), .T_CMD(TC), .T_CLR(TCLR)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_byte(req0_byte), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_byte(req1_byte), .req1_ready(req1_ready),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
        .init_done(init_done), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record {rs, db} at every E falling edge; a reset-forced fall is not a write.
    int   obs_q[$];
    logic prev_e = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_e <= 1'b0;
        end else begin
            if (prev_e && !lcd_e) obs_q.push_back(int'({lcd_rs, lcd_db}));
            prev_e <= lcd_e;
        end
    end

    int total = 0, bad = 0;
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    int         init_nib[12] = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 1, 0, 6};
    int         exp_q[$];
    logic       pend_v[2], pend_rs[2];
    logic [7:0] pend_byte[2];
    int         k_edge, next_ok, accepts;
    logic       last_grant;

    task automatic release_rst();
        rst = 1'b0;
        k_edge = cyc;
        next_ok = k_edge + INIT_TOTAL + 1;
        last_grant = 1'b1;
        exp_q.delete();
        foreach (init_nib[i]) exp_q.push_back(init_nib[i]);
    endtask

    task automatic new_req(input int p);
        pend_v[p] = 1'b1;
        pend_rs[p] = 1'($urandom_range(0, 1));
        pend_byte[p] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) begin
            pend_rs[p] = 1'b0;
            pend_byte[p] = 8'($urandom_range(1, 3));
        end
    endtask

    // One clock: compare E-fall nibbles, drive requests, check ready/busy/state vs the model.
    task automatic tick();
        int   e, o, p, w;
        logic can, g0, g1;
        @(posedge clk);
        #1;
        e = cyc;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) check_eq("unexpected_nibble", 32'(o), 32'h100);
            else check_eq("e_fall_nibble", 32'(o), 32'(exp_q.pop_front()));
        end
        req0_valid = pend_v[0]; req0_rs = pend_rs[0]; req0_byte = pend_byte[0];
        req1_valid = pend_v[1]; req1_rs = pend_rs[1]; req1_byte = pend_byte[1];
        #1;
        can = (e + 1 >= next_ok);
        g0 = can && pend_v[0] && (!pend_v[1] || last_grant);
        g1 = can && pend_v[1] && (!pend_v[0] || !last_grant);
        check_eq("req0_ready", 32'(req0_ready), 32'(g0));
        check_eq("req1_ready", 32'(req1_ready), 32'(g1));
        check_eq("busy", 32'(busy), 32'(!can || g0 || g1));
        check_eq("idle_state", 32'(dbg_state == 5'd5), 32'(can));
        check_eq("init_done", 32'(init_done), 32'(e >= k_edge + INIT_TOTAL));
        check_eq("lcd_rw", 32'(lcd_rw), 32'd0);
        if (g0 || g1) begin
            p = g1 ? 1 : 0;
            exp_q.push_back(int'({pend_rs[p], pend_byte[p][7:4]}));
            exp_q.push_back(int'({pend_rs[p], pend_byte[p][3:0]}));
            w = (!pend_rs[p] && pend_byte[p] >= 8'h01 && pend_byte[p] <= 8'h03) ? TCLR : TC;
            next_ok = e + 2 + XFER + w;
            last_grant = g1;
            pend_v[p] = 1'b0;
            accepts++;
        end
    endtask

    initial begin
        logic found;
        accepts = 0;
        for (int p = 0; p < 2; p++) begin
            pend_v[p] = 1'b0; pend_rs[p] = 1'b0; pend_byte[p] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        // Port 0 already waiting from reset with 'A' as data.
        pend_v[0] = 1'b1; pend_rs[0] = 1'b1; pend_byte[0] = 8'h41;
        release_rst();
        repeat (INIT_TOTAL + 40) tick();
        check_eq("first_accept", 32'(accepts), 32'd1);

        // Both ports continuously valid: arbitration must alternate.
        for (int n = 0; n < 8; n++) begin
            for (int p = 0; p < 2; p++) if (!pend_v[p]) new_req(p);
            tick();
            repeat (60) begin
                for (int p = 0; p < 2; p++) if (!pend_v[p]) new_req(p);
                tick();
            end
        end

        // Sparse random traffic with occasional withdrawal before ready.
        repeat (3000) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend_v[p] && $urandom_range(0, 15) == 0) new_req(p);
                else if (pend_v[p] && $urandom_range(0, 63) == 0) pend_v[p] = 1'b0;
            end
            tick();
        end

        // Reset in the middle of a byte while E is high.
        found = 1'b0;
        if (!pend_v[0]) new_req(0);
        for (int n = 0; n < 200 && !found; n++) begin
            tick();
            if (dbg_state == 5'd2 && init_done) found = 1'b1;
        end
        check_eq("saw_pulse_before_reset", 32'(found), 32'd1);
        pend_v[0] = 1'b0; pend_v[1] = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_lcd_e", 32'(lcd_e), 32'd0);
        check_eq("rst_init_done", 32'(init_done), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        release_rst();
        repeat (INIT_TOTAL + 60) tick();
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
